fm6126_cfg_monitor: RTL

- Receive-side decoder for the FM6126A panel configuration protocol, i.e. the panel end of the init sequencer's rgb/latch/clock lines.
- Watches the panel shift clock, RGB data lines and latch while init is active (mask_en high).
- Decodes REG1/REG2 writes from the latch-high clock count and captures the 16-bit value shifted in.
- Used as an on-chip self-check in simulation and for debug readout on hardware.

---
 rtl/fm6126_pkg.sv | 18 +
 rtl/fm6126_edge_sync.sv | 34 +++
 rtl/fm6126_cfg_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fm6126_pkg.sv
// Shared FM6126A protocol definitions.
// Used by the config monitor and by the init sequencer so both ends agree on
// the shift-register width and the latch-length command encoding.
package fm6126_pkg;

  localparam int unsigned FM6126_CHIP_BITS  = 16;
  localparam int unsigned FM6126_REG1_LATCH = 12;
  localparam int unsigned FM6126_REG2_LATCH = 13;

  // Command decoded from the number of shift edges seen with latch high.
  typedef enum logic [1:0] {
    CMD_DATA    = 2'd0,
    CMD_REG1    = 2'd1,
    CMD_REG2    = 2'd2,
    CMD_UNKNOWN = 2'd3
  } cmd_code_t;

endpackage

// File: rtl/fm6126_edge_sync.sv
// One-bit input register with a previous-value register and edge outputs.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   d        : raw input pin
//   q        : registered input
//   rise     : q high while previous sample was low
//   fall     : q low while previous sample was high
module fm6126_edge_sync
  import fm6126_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      q    <= d;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/fm6126_cfg_monitor.sv
// FM6126A configuration monitor: panel-side decoder of the init sequencer's
// shift clock / RGB / latch lines. Captures REG1/REG2 writes, flags data-line
// disagreement and reports every completed latch command.
// Ports:
//   clk_in, reset          : system clock, asynchronous active-high reset
//   mask_en                : init window; decoding only while high
//   shift_clk_in           : panel shift clock (sampled in clk_in domain)
//   rgb1_in, rgb2_in       : upper/lower RGB data lines
//   latch_in               : panel latch line
//   reg1_value, reg2_value : last decoded register values
//   reg1_valid, reg2_valid : sticky, set by first write of each register
//   cmd_strobe, cmd_code   : one-cycle pulse and code of a completed command
//   err_mismatch           : sticky, data lines disagreed on a shift edge
module fm6126_cfg_monitor
  import fm6126_pkg::*;
#(
  parameter int unsigned CHIP_BITS   = FM6126_CHIP_BITS,
  parameter int unsigned REG1_LATCH  = FM6126_REG1_LATCH,
  parameter int unsigned REG2_LATCH  = FM6126_REG2_LATCH,
  parameter int unsigned LATCH_CNT_W = 5
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 mask_en,
  input  logic                 shift_clk_in,
  input  logic [2:0]           rgb1_in,
  input  logic [2:0]           rgb2_in,
  input  logic                 latch_in,
  output logic [CHIP_BITS-1:0] reg1_value,
  output logic [CHIP_BITS-1:0] reg2_value,
  output logic                 reg1_valid,
  output logic                 reg2_valid,
  output logic                 cmd_strobe,
  output logic [1:0]           cmd_code,
  output logic                 err_mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCHED = 2'd2
  } mon_state_t;

  mon_state_t             state, next_state;
  logic                   s_shift, shift_rise, shift_fall_unused;
  logic                   s_latch, latch_rise_unused, latch_fall;
  logic [2:0]             s_rgb1, s_rgb2;
  logic [CHIP_BITS-1:0]   sr, sr_next;
  logic [LATCH_CNT_W-1:0] cnt, cnt_next;
  logic                   shift_ev, fall_ev, lines_bad;
  cmd_code_t              dec_code;
  logic                   s_shift_unused;

  fm6126_edge_sync u_shift_sync (
    .clk  (clk_in),
    .rst  (reset),
    .d    (shift_clk_in),
    .q    (s_shift),
    .rise (shift_rise),
    .fall (shift_fall_unused)
  );

  fm6126_edge_sync u_latch_sync (
    .clk  (clk_in),
    .rst  (reset),
    .d    (latch_in),
    .q    (s_latch),
    .rise (latch_rise_unused),
    .fall (latch_fall)
  );

  assign s_shift_unused = s_shift;

  // RGB lines share the same single register stage so data lines up with s_shift.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s_rgb1 <= '0;
      s_rgb2 <= '0;
    end else begin
      s_rgb1 <= rgb1_in;
      s_rgb2 <= rgb2_in;
    end
  end

  always_comb begin
    shift_ev   = mask_en & shift_rise;
    fall_ev    = mask_en & latch_fall;
    lines_bad  = ({s_rgb1, s_rgb2} != 6'b000000) && ({s_rgb1, s_rgb2} != 6'b111111);
    sr_next    = sr;
    cnt_next   = cnt;
    next_state = state;

    // The edge is folded into sr_next before decode, so a shift edge coinciding
    // with latch fall is captured in the register value (uncounted, latch low).
    if (!mask_en) begin
      sr_next  = '0;
      cnt_next = '0;
    end else begin
      if (shift_ev) begin
        sr_next = {sr[CHIP_BITS-2:0], s_rgb1[0]};
        if (s_latch && (cnt != '1)) cnt_next = cnt + LATCH_CNT_W'(1);
      end
      if (fall_ev) cnt_next = '0;
    end

    if (cnt <= LATCH_CNT_W'(3))                dec_code = CMD_DATA;
    else if (cnt == LATCH_CNT_W'(REG1_LATCH))  dec_code = CMD_REG1;
    else if (cnt == LATCH_CNT_W'(REG2_LATCH))  dec_code = CMD_REG2;
    else                                       dec_code = CMD_UNKNOWN;

    case (state)
      ST_IDLE:    if (shift_ev) next_state = ST_SHIFT;
      ST_SHIFT:   if (shift_ev && s_latch) next_state = ST_LATCHED;
      ST_LATCHED: if (fall_ev) next_state = ST_SHIFT;
      default:    next_state = ST_IDLE;
    endcase
    if (!mask_en) next_state = ST_IDLE;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sr           <= '0;
      cnt          <= '0;
      reg1_value   <= '0;
      reg2_value   <= '0;
      reg1_valid   <= 1'b0;
      reg2_valid   <= 1'b0;
      cmd_strobe   <= 1'b0;
      cmd_code     <= '0;
      err_mismatch <= 1'b0;
    end else begin
      state      <= next_state;
      sr         <= sr_next;
      cnt        <= cnt_next;
      cmd_strobe <= fall_ev;
      if (shift_ev && lines_bad) err_mismatch <= 1'b1;
      if (fall_ev) begin
        cmd_code <= dec_code;
        if (dec_code == CMD_REG1) begin
          reg1_value <= sr_next;
          reg1_valid <= 1'b1;
        end
        if (dec_code == CMD_REG2) begin
          reg2_value <= sr_next;
          reg2_valid <= 1'b1;
        end
      end
    end
  end

endmodule
